// File: rtl/store_buffer.sv
// Circular FIFO of pending stores between the store unit and the data-cache store controller,
// with a combinational load-address check for store-to-load forwarding.

package store_buffer_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } store_width_e;

  typedef struct packed {
    logic [31:0]  address;
    logic [31:0]  data;
    store_width_e store_width;
  } store_buffer_entry_t;

endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                halt_i,
  input  logic                push_i,
  input  store_buffer_entry_t push_entry_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                request_o,
  output store_buffer_entry_t entry_o,
  input  logic                valid_i,
  input  logic [31:0]         load_address_i,
  output logic                forward_valid_o,
  output logic [31:0]         forward_data_o,
  output logic                conflict_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  store_buffer_entry_t entries_q [DEPTH];
  store_buffer_entry_t entries_d [DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic push_ok;
  logic pop_ok;

  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign request_o = !empty_o;
  assign entry_o   = entries_q[rd_ptr_q];

  // Both acceptances use the pre-edge count, so a push while full is rejected even if popping.
  assign push_ok = push_i && !full_o && !halt_i;
  assign pop_ok  = valid_i && !empty_o && !halt_i;

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    valid_d   = valid_q;
    count_d   = count_q + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop_ok};
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      entries_d[wr_ptr_q] = push_entry_i;
      valid_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; only entries covered by valid_q are ever observed.
  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
  end

  logic            fwd_hit;
  logic [PtrW-1:0] fwd_idx;
  logic [PtrW-1:0] scan_idx;
  logic            fwd_ok;

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PtrW'(i);
      if (valid_q[scan_idx] &&
          (entries_q[scan_idx].address[31:2] == load_address_i[31:2])) begin
        fwd_hit = 1'b1;
        fwd_idx = scan_idx;
      end
    end
  end

  always_comb begin
    fwd_ok = fwd_hit &&
             (entries_q[fwd_idx].store_width == WORD) &&
             (entries_q[fwd_idx].address[1:0] == 2'b00) &&
             (load_address_i[1:0] == 2'b00);
    forward_valid_o = fwd_ok;
    conflict_o      = fwd_hit && !fwd_ok;
    forward_data_o  = fwd_ok ? entries_q[fwd_idx].data : 32'h0;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Circular FIFO of pending stores between the store unit (execution stage) and the data-cache store controller.
- Accepts one store_buffer_entry_t per cycle from the store unit.
- Presents the oldest entry to the store controller with a request/valid handshake, and retires it when the controller reports completion.
- Provides a combinational address check so the load path can forward data from a buffered store, or stall on a partial overlap.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- halt_i  in  1  pipeline halt; freezes all state
- push_i  in  1  store unit writes push_entry_i
- push_entry_i  in  store_buffer_entry_t  fields: address (32), data (32), store_width (BYTE/HALF_WORD/WORD)
- full_o  out  1  no free entry
- empty_o  out  1  no valid entry
- request_o  out  1  head entry pending, to store controller request_i
- entry_o  out  store_buffer_entry_t  head entry, to store controller buffer_entry_i
- valid_i  in  1  store controller valid_o; head store completed
- load_address_i  in  32  address of the load being issued
- forward_valid_o  out  1  load data is fully supplied by a buffered store
- forward_data_o  out  32  forwarded word
- conflict_o  out  1  load overlaps a buffered store that cannot be forwarded

Behaviour:
- State:
  - Entry array, DEPTH entries.
  - Read pointer and write pointer, each clog2(DEPTH) bits; both wrap modulo DEPTH.
  - Count, clog2(DEPTH)+1 bits.
  - Per-entry valid bits.
- Reset (asynchronous):
  - Pointers, count and valid bits cleared.
  - full_o=0, empty_o=1, request_o=0, forward_valid_o=0, conflict_o=0.
  - entry_o and forward_data_o are don't-care.
- Flag decode (from count, combinational):
  - full_o = (count==DEPTH).
  - empty_o = (count==0).
  - request_o = !empty_o.
- Halt: while halt_i=1, push_i and valid_i are ignored and no register changes; outputs keep their current values.
- Push: accepted at the clock edge when push_i && !full_o && !halt_i.
  - Entry is written at the write pointer, its valid bit is set, and the write pointer increments.
  - A push while full is dropped; the buffer is unchanged. The store unit must stall on full_o.
- Head presentation:
  - entry_o = entry at the read pointer, combinational.
  - entry_o stays stable while request_o=1 until the pop.
- Pop: occurs at the clock edge when valid_i && !empty_o && !halt_i.
  - Clears the head valid bit and increments the read pointer.
  - valid_i while empty is ignored.
- Head-to-head latency:
  - The controller pulses valid_i for one cycle and returns to IDLE.
  - The next head is visible on entry_o, with request_o=1 if count>0, in the following cycle.
  - The controller samples it in IDLE, so there are no bubbles beyond the controller's own cycles.
- Simultaneous push and pop (not full, not empty): both happen and count is unchanged.
  - When full, the pop happens but the push is still rejected, because full_o is evaluated from the pre-edge count.
- Wrap-around: pointers wrap from DEPTH-1 to 0; count alone distinguishes full from empty.
- Forwarding (combinational, same cycle):
  - Compare load_address_i[31:2] against address[31:2] of every valid entry. The head is included even if it is popping this cycle.
  - Select the youngest match, i.e. the closest to the write pointer going backwards.
  - If that match has store_width==WORD and address[1:0]==load_address_i[1:0]==0: forward_valid_o=1, forward_data_o = its data, conflict_o=0.
  - Any other match: conflict_o=1, forward_valid_o=0.
  - No match: both 0, forward_data_o=0.
  - An entry pushed in the current cycle is not visible until the next cycle.

Test Plan:
- Reset then push A (0x100, WORD, 0xDEADBEEF) -> next cycle request_o=1, entry_o=A, empty_o=0. Pulse valid_i -> next cycle empty_o=1, request_o=0.
- With DEPTH=4, push 4 entries without pops -> full_o=1. A fifth push is dropped. Pop 4 -> entries come out in FIFO order and empty_o=1.
- Hold 3 entries; push and pop in the same cycle for 10 cycles -> count stays 3, pointers wrap correctly, order is preserved.
- Buffer holds WORD 0x200=0x11111111 then WORD 0x200=0x22222222; load 0x200 -> forward_valid_o=1, forward_data_o=0x22222222. Load 0x204 -> both flags 0.
- Buffer holds BYTE at 0x301; load 0x300 -> conflict_o=1, forward_valid_o=0.
- Assert halt_i with push_i and valid_i high for 3 cycles -> no state change. Assert rst_n_i low mid-stream, asynchronously, with no clock edge -> empty_o=1 and request_o=0 immediately.
